// File: rtl/v810_bus_arb_if.sv
// v810_bus_arb_if: fetch port, data port and external bus signals
// grouped for the V810 bus arbiter.
interface v810_bus_arb_if;
    logic        I_REQ;
    logic [31:0] I_A;
    logic [31:0] I_D;
    logic        I_ACK;
    logic        D_REQ;
    logic [31:0] D_A;
    logic [31:0] D_WD;
    logic [3:0]  D_BEn;
    logic [1:0]  D_ST;
    logic        D_RW;
    logic [31:0] D_RD;
    logic        D_ACK;
    logic        STALL;
    logic        BUS_ERR;
    logic [31:0] A;
    logic [31:0] DO;
    logic [31:0] DI;
    logic [3:0]  BEn;
    logic [1:0]  ST;
    logic        RW;
    logic        BCYSTn;
    logic        DAn;
    logic        READYn;

    modport master (
        input  I_REQ, I_A, D_REQ, D_A, D_WD, D_BEn, D_ST, D_RW,
        input  DI, READYn,
        output I_D, I_ACK, D_RD, D_ACK, STALL, BUS_ERR,
        output A, DO, BEn, ST, RW, BCYSTn, DAn
    );

    modport slave (
        output I_REQ, I_A, D_REQ, D_A, D_WD, D_BEn, D_ST, D_RW,
        output DI, READYn,
        input  I_D, I_ACK, D_RD, D_ACK, STALL, BUS_ERR,
        input  A, DO, BEn, ST, RW, BCYSTn, DAn
    );
endinterface

// File: rtl/v810_bus_arb.sv
// v810_bus_arb: merges the V810 fetch and data ports onto one
// external bus and runs the IDLE/T1/T2 bus cycle machine.
module v810_bus_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [1:0]  ST_FETCH       = 2'b10
) (
    input logic            CLK,
    input logic            RES,
    input logic            CE,
    v810_bus_arb_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_T1,
        S_T2
    } state_t;

    localparam logic [10:0] TO = 11'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_cnt;
    logic        r_last_d;
    logic        r_gnt_d;
    logic [31:0] r_a;
    logic [31:0] r_do;
    logic [3:0]  r_ben;
    logic [1:0]  r_st;
    logic        r_rw;
    logic        r_bcyst_n;
    logic        r_da_n;
    logic        r_i_ack;
    logic        r_d_ack;
    logic [31:0] r_i_d;
    logic [31:0] r_d_rd;
    logic        r_bus_err;

    logic        w_i_pend;
    logic        w_d_pend;
    logic        w_start;
    logic        w_sel_d;
    logic        w_done;
    logic        w_err;
    logic [10:0] w_cnt_inc;

    // A REQ still high in its own ACK cycle is the old request.
    always_comb begin
        w_i_pend    = bus.I_REQ & ~r_i_ack;
        w_d_pend    = bus.D_REQ & ~r_d_ack;
        w_cnt_inc   = {1'b0, r_cnt} + 11'd1;
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_sel_d     = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_i_pend | w_d_pend) begin
                    w_start     = 1'b1;
                    w_sel_d     = w_d_pend & (~w_i_pend | ~r_last_d);
                    w_state_nxt = S_T1;
                end
            end
            S_T1: w_state_nxt = S_T2;
            S_T2: begin
                if (!bus.READYn) begin
                    w_done = 1'b1;
                end else if (w_cnt_inc >= TO) begin
                    w_done = 1'b1;
                    w_err  = 1'b1;
                end
                if (w_done) begin
                    if (r_gnt_d ? w_i_pend : w_d_pend) begin
                        w_start     = 1'b1;
                        w_sel_d     = ~r_gnt_d;
                        w_state_nxt = S_T1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state <= S_IDLE;
        end else if (CE) begin
            r_state <= w_state_nxt;
        end
    end

    // Bus outputs, wait counter, grant history and return data.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_cnt     <= '0;
            r_last_d  <= 1'b0;
            r_gnt_d   <= 1'b0;
            r_a       <= '0;
            r_do      <= '0;
            r_ben     <= 4'hF;
            r_st      <= 2'b00;
            r_rw      <= 1'b1;
            r_bcyst_n <= 1'b1;
            r_da_n    <= 1'b1;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_d     <= '0;
            r_d_rd    <= '0;
            r_bus_err <= 1'b0;
        end else if (CE) begin
            r_bcyst_n <= ~(w_state_nxt == S_T1);
            r_da_n    <= ~(w_state_nxt == S_T1 || w_state_nxt == S_T2);
            r_i_ack   <= w_done & ~r_gnt_d;
            r_d_ack   <= w_done & r_gnt_d;
            r_bus_err <= w_err;
            if (r_state == S_T1) begin
                r_cnt <= '0;
            end else if (r_state == S_T2 && bus.READYn && !w_done) begin
                r_cnt <= w_cnt_inc[9:0];
            end
            if (w_done) begin
                if (w_err) begin
                    if (r_gnt_d) r_d_rd <= '0;
                    else         r_i_d  <= '0;
                end else if (r_rw) begin
                    if (r_gnt_d) r_d_rd <= bus.DI;
                    else         r_i_d  <= bus.DI;
                end
            end
            if (w_start) begin
                r_gnt_d  <= w_sel_d;
                r_last_d <= w_sel_d;
                if (w_sel_d) begin
                    r_a   <= bus.D_A;
                    r_ben <= bus.D_BEn;
                    r_st  <= bus.D_ST;
                    r_rw  <= bus.D_RW;
                    if (!bus.D_RW) r_do <= bus.D_WD;
                end else begin
                    r_a   <= bus.I_A;
                    r_ben <= 4'h0;
                    r_st  <= ST_FETCH;
                    r_rw  <= 1'b1;
                end
            end
        end
    end

    assign bus.STALL   = (bus.I_REQ & ~r_i_ack) | (bus.D_REQ & ~r_d_ack);
    assign bus.I_D     = r_i_d;
    assign bus.I_ACK   = r_i_ack;
    assign bus.D_RD    = r_d_rd;
    assign bus.D_ACK   = r_d_ack;
    assign bus.BUS_ERR = r_bus_err;
    assign bus.A       = r_a;
    assign bus.DO      = r_do;
    assign bus.BEn     = r_ben;
    assign bus.ST      = r_st;
    assign bus.RW      = r_rw;
    assign bus.BCYSTn  = r_bcyst_n;
    assign bus.DAn     = r_da_n;
endmodule

// File: tb/tb_v810_bus_arb.sv
// tb_v810_bus_arb: randomized and directed bus episodes checked
// against a transaction-level timing/ordering model.
module tb_v810_bus_arb;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic res;
    logic ce;

    v810_bus_arb_if bif ();

    v810_bus_arb #(
        .TIMEOUT_CYCLES(TO),
        .ST_FETCH      (2'b10)
    ) dut (
        .CLK(clk),
        .RES(res),
        .CE (ce),
        .bus(bif)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model state
    bit          m_last_d;
    logic [31:0] m_do;
    logic [31:0] m_id;
    logic [31:0] m_drd;

    // episode plan
    bit          p_i;
    bit          p_d;
    logic [31:0] p_ia;
    logic [31:0] p_da;
    logic [31:0] p_wd;
    logic [3:0]  p_ben;
    logic [1:0]  p_st;
    bit          p_rw;
    int          p_w[2];
    logic [31:0] p_di[2];

    task automatic rand_plan();
        int m;
        m     = $urandom_range(1, 3);
        p_i   = m[0];
        p_d   = m[1];
        p_ia  = $urandom;
        p_da  = $urandom;
        p_wd  = $urandom;
        p_ben = 4'($urandom);
        p_st  = 2'($urandom);
        p_rw  = 1'($urandom);
        for (int k = 0; k < 2; k++) begin
            p_w[k]  = $urandom_range(0, 5);
            p_di[k] = $urandom;
        end
    endtask

    task automatic run_ep();
        int n, cyc, t1n, ackn, errn, exp_err, cur, rem, k;
        bit ord[2];
        bit errx[2];
        int t1c[2];
        int ackc[2];
        bit in_t2, drop_i, drop_d;
        n      = int'(p_i) + int'(p_d);
        ord[0] = (p_i && p_d) ? !m_last_d : p_d;
        ord[1] = !ord[0];
        exp_err = 0;
        for (int j = 0; j < 2; j++) begin
            errx[j] = (p_w[j] >= TO);
            if (j < n && errx[j]) exp_err++;
        end
        t1c[0]   = 1;
        ackc[0]  = 3 + (errx[0] ? TO - 1 : p_w[0]);
        t1c[1]   = ackc[0];
        ackc[1]  = t1c[1] + 2 + (errx[1] ? TO - 1 : p_w[1]);
        m_last_d = ord[n-1];
        bif.I_A   = p_ia;
        bif.D_A   = p_da;
        bif.D_WD  = p_wd;
        bif.D_BEn = p_ben;
        bif.D_ST  = p_st;
        bif.D_RW  = p_rw;
        bif.I_REQ = p_i;
        bif.D_REQ = p_d;
        #1;
        chk("stall_req", 32'(bif.STALL), 32'd1);
        cyc = 0; t1n = 0; ackn = 0; errn = 0;
        cur = 0; rem = 0; in_t2 = 0; drop_i = 0; drop_d = 0;
        repeat (ackc[n-1] + 3) begin
            tick();
            cyc++;
            if (drop_i) begin bif.I_REQ = 1'b0; drop_i = 0; end
            if (drop_d) begin bif.D_REQ = 1'b0; drop_d = 0; end
            if (!bif.BCYSTn) begin
                if (t1n < n) begin
                    cur = t1n;
                    chk("t1_cyc", 32'(cyc), 32'(t1c[cur]));
                    if (ord[cur]) begin
                        if (!p_rw) m_do = p_wd;
                        chk("a_d", bif.A, p_da);
                        chk("ben_d", 32'(bif.BEn), 32'(p_ben));
                        chk("st_d", 32'(bif.ST), 32'(p_st));
                        chk("rw_d", 32'(bif.RW), 32'(p_rw));
                    end else begin
                        chk("a_i", bif.A, p_ia);
                        chk("ben_i", 32'(bif.BEn), 32'h0);
                        chk("st_i", 32'(bif.ST), 32'h2);
                        chk("rw_i", 32'(bif.RW), 32'h1);
                    end
                    chk("dan_t1", 32'(bif.DAn), 32'h0);
                    chk("do", bif.DO, m_do);
                    rem   = p_w[cur];
                    in_t2 = 1;
                end
                t1n++;
                bif.READYn = 1'b1;
            end else if (in_t2) begin
                bif.READYn = (rem > 0);
                if (rem > 0) rem--;
                else in_t2 = 0;
            end else begin
                bif.READYn = 1'b1;
            end
            bif.DI = p_di[cur];
            if (bif.I_ACK || bif.D_ACK) begin
                ackn++;
                k = (ord[0] == bif.D_ACK) ? 0 : 1;
                if (k < n) begin
                    chk("ack_cyc", 32'(cyc), 32'(ackc[k]));
                    chk("bus_err", 32'(bif.BUS_ERR), 32'(errx[k]));
                    if (ord[k]) begin
                        if (errx[k]) m_drd = '0;
                        else if (p_rw) m_drd = p_di[k];
                        chk("d_rd", bif.D_RD, m_drd);
                        drop_d = 1;
                    end else begin
                        m_id = errx[k] ? '0 : p_di[k];
                        chk("i_d", bif.I_D, m_id);
                        drop_i = 1;
                    end
                end
            end
            if (bif.BUS_ERR) errn++;
        end
        chk("t1_count", 32'(t1n), 32'(n));
        chk("ack_count", 32'(ackn), 32'(n));
        chk("err_count", 32'(errn), 32'(exp_err));
        chk("stall_idle", 32'(bif.STALL), 32'h0);
    endtask

    initial begin
        res        = 1'b1;
        ce         = 1'b1;
        bif.I_REQ  = 1'b0;
        bif.I_A    = '0;
        bif.D_REQ  = 1'b0;
        bif.D_A    = '0;
        bif.D_WD   = '0;
        bif.D_BEn  = 4'hF;
        bif.D_ST   = 2'b00;
        bif.D_RW   = 1'b1;
        bif.DI     = '0;
        bif.READYn = 1'b1;
        m_last_d   = 0;
        m_do       = '0;
        m_id       = '0;
        m_drd      = '0;
        repeat (3) tick();
        chk("rst_a", bif.A, 32'h0);
        chk("rst_do", bif.DO, 32'h0);
        chk("rst_ben", 32'(bif.BEn), 32'hF);
        chk("rst_st", 32'(bif.ST), 32'h0);
        chk("rst_rw", 32'(bif.RW), 32'h1);
        chk("rst_bcyst", 32'(bif.BCYSTn), 32'h1);
        chk("rst_dan", 32'(bif.DAn), 32'h1);
        chk("rst_iack", 32'(bif.I_ACK), 32'h0);
        chk("rst_dack", 32'(bif.D_ACK), 32'h0);
        chk("rst_id", bif.I_D, 32'h0);
        chk("rst_drd", bif.D_RD, 32'h0);
        chk("rst_err", 32'(bif.BUS_ERR), 32'h0);
        res = 1'b0;
        tick();

        // single zero-wait fetch
        rand_plan();
        p_i = 1; p_d = 0; p_ia = 32'h0000_1000;
        p_w[0] = 0; p_di[0] = 32'hDEAD_BEEF;
        run_ep();
        // write with two waits
        rand_plan();
        p_i = 0; p_d = 1; p_rw = 0;
        p_da = 32'h0500_0004; p_wd = 32'h1234_5678; p_ben = 4'b1100;
        p_w[0] = 2;
        run_ep();
        // contention, twice to exercise alternation
        for (int r = 0; r < 2; r++) begin
            rand_plan();
            p_i = 1; p_d = 1; p_w[0] = 0; p_w[1] = 0;
            run_ep();
        end
        // timeout on a data read
        rand_plan();
        p_i = 0; p_d = 1; p_rw = 1; p_w[0] = 6;
        run_ep();

        for (int r = 0; r < 60; r++) begin
            rand_plan();
            run_ep();
        end

        // reset mid-T2
        bif.D_A    = 32'h0000_0040;
        bif.D_RW   = 1'b1;
        bif.D_BEn  = 4'h0;
        bif.READYn = 1'b1;
        bif.D_REQ  = 1'b1;
        tick();
        chk("rst_t1", 32'(bif.BCYSTn), 32'h0);
        tick();
        res = 1'b1;
        tick();
        res       = 1'b0;
        bif.D_REQ = 1'b0;
        chk("rstmid_bcyst", 32'(bif.BCYSTn), 32'h1);
        chk("rstmid_dan", 32'(bif.DAn), 32'h1);
        chk("rstmid_ben", 32'(bif.BEn), 32'hF);
        chk("rstmid_a", bif.A, 32'h0);
        m_last_d = 0;
        m_do     = '0;
        m_id     = '0;
        m_drd    = '0;
        repeat (4) begin
            tick();
            chk("rstmid_noack", 32'(bif.D_ACK), 32'h0);
        end

        // CE low for three cycles in T2
        bif.D_A    = 32'h0000_0080;
        bif.D_RW   = 1'b1;
        bif.READYn = 1'b0;
        bif.DI     = 32'hCAFE_F00D;
        bif.D_REQ  = 1'b1;
        tick();
        chk("ce_t1", 32'(bif.BCYSTn), 32'h0);
        tick();
        ce = 1'b0;
        repeat (3) begin
            tick();
            chk("ce_dan", 32'(bif.DAn), 32'h0);
            chk("ce_bcyst", 32'(bif.BCYSTn), 32'h1);
            chk("ce_noack", 32'(bif.D_ACK), 32'h0);
        end
        ce = 1'b1;
        tick();
        chk("ce_ack", 32'(bif.D_ACK), 32'h1);
        chk("ce_drd", bif.D_RD, 32'hCAFE_F00D);
        m_last_d = 1;
        m_drd    = 32'hCAFE_F00D;
        tick();
        bif.D_REQ  = 1'b0;
        bif.READYn = 1'b1;
        repeat (2) tick();

        for (int r = 0; r < 20; r++) begin
            rand_plan();
            run_ep();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/v810_bus_arb.md
# v810_bus_arb

Arbitrates the V810 core's separate instruction-fetch port and data port onto the single external 32-bit memory bus. It runs the bus cycle state machine (address phase, data/wait phase, completion) and returns read data and one-cycle acknowledges to each requester. It sits between the execution pipeline (IA/ID, DA/DD/BEn/ST/MRQn/RW) and the system bus.

## Interface
- TIMEOUT_CYCLES, 255: READYn-high cycles tolerated in T2 before a bus error completes the cycle; range 1..1023.
- ST_FETCH, 2'b10: ST code driven on instruction fetches. Data cycles drive D_ST.

Ports (all sampled/updated on CLK rising edge when CE=1):
- CLK  in  1  system clock
- RES  in  1  reset; synchronous, active-high
- CE  in  1  global clock enable; CE=0 freezes all state and outputs
- I_REQ  in  1  fetch request; held until I_ACK
- I_A  in  32  fetch address; stable while I_REQ
- I_D  out  32  fetch data; valid when I_ACK
- I_ACK  out  1  one-cycle fetch completion
- D_REQ  in  1  data request; held until D_ACK
- D_A  in  32  data address
- D_WD  in  32  write data
- D_BEn  in  4  byte enables, active-low
- D_ST  in  2  data-cycle status code
- D_RW  in  1  1=read, 0=write
- D_RD  out  32  read data; valid when D_ACK
- D_ACK  out  1  one-cycle data completion
- STALL  out  1  combinational: (I_REQ & ~I_ACK) | (D_REQ & ~D_ACK)
- BUS_ERR  out  1  one-cycle pulse, coincident with the ACK of a timed-out cycle
- A  out  32  bus address
- DO  out  32  bus write data
- DI  in  32  bus read data
- BEn  out  4  bus byte enables
- ST  out  2  bus status
- RW  out  1  1=read, 0=write
- BCYSTn  out  1  bus cycle start, low for exactly the T1 cycle
- DAn  out  1  data strobe, low during T1 and T2
- READYn  in  1  slave ready, sampled in T2

## Operation
- States: IDLE, T1, T2.
- IDLE: if any request pending, select a grant and go to T1. Latch A/BEn/ST/RW/DO from the winner. Fetches drive BEn=4'h0, RW=1, ST=ST_FETCH.
- Grant rule when both are pending: D wins unless the previous grant was D, then I wins (alternation). A single request always wins.
- T1: BCYSTn=0, DAn=0, then go to T2. Clear the wait counter.
- T2: DAn=0. Sample READYn each cycle.
  - READYn=0: capture DI into I_D or D_RD (reads only; writes leave the data register unchanged). Pulse the winner's ACK next cycle.
  - READYn=1: increment the counter. When the counter reaches TIMEOUT_CYCLES, complete with data 32'h0 and BUS_ERR=1.
- Completion: if the other requester is pending, go directly to T1 with a new grant (back-to-back). Otherwise go to IDLE.
  - The requester just completed is excluded from this grant decision, because its REQ is still high until it sees ACK.
- DO is driven from D_WD on write cycles. On read cycles DO holds its last value.
- Requests that arrive or drop while another cycle is in progress are not sampled until the next grant decision.
  - A requester dropping REQ before its ACK is a protocol violation; the cycle still completes.

## Timing
- All outputs are registered except STALL.
- Reset values: A=0, DO=0, BEn=4'hF, ST=2'b00, RW=1, BCYSTn=1, DAn=1, I_ACK=0, D_ACK=0, I_D=0, D_RD=0, BUS_ERR=0. State=IDLE, counter=0, last grant=I.
- Zero-wait latency:
  - Cycle 0: REQ sampled in IDLE.
  - Cycle 1: T1 on the bus.
  - Cycle 2: T2, READYn=0.
  - Cycle 3: ACK=1 with data.
  - Each READYn-high cycle adds 1.
- Back-to-back cycles: the ACK cycle of one transfer is the T1 cycle of the next. Sustained throughput is 2 cycles per zero-wait access.
- RES asserted in any state, including mid-T2: the next edge restores all reset values, no ACK is issued, and the aborted requester must re-request.
- CE=0: state, counter, and outputs hold. READYn is not sampled.
- The counter is wide enough for 1023 and never wraps.

## Test plan
- Single read, zero waits: I_REQ=1, I_A=32'h0000_1000, DI=32'hDEAD_BEEF, READYn=0 in T2 -> BCYSTn low in cycle 1, A=32'h1000, ST=2'b10, I_ACK and I_D=32'hDEAD_BEEF in cycle 3.
- Write with 2 waits: D_REQ=1, D_RW=0, D_A=32'h0500_0004, D_WD=32'h1234_5678, D_BEn=4'b1100, READYn=1,1,0 -> DO=32'h1234_5678, BEn=4'b1100, RW=0, D_ACK in cycle 5, D_RD unchanged.
- Contention: I_REQ and D_REQ both raised in the same cycle, both held -> D serviced first (D_ACK cycle 3), I back-to-back (T1 in cycle 3, I_ACK cycle 5), no gap cycle.
- Alternation: D_REQ held continuously and re-requested after each ACK, with I_REQ pending -> grant order D, I, D, I; I never waits more than one D cycle.
- Timeout: TIMEOUT_CYCLES=4, READYn held 1 -> D_ACK and BUS_ERR together after 4 T2 cycles, D_RD=0, return to IDLE.
- Reset and CE: assert RES for 1 cycle mid-T2 -> next cycle BCYSTn=1, DAn=1, BEn=4'hF, no ACK. Separately, CE=0 for 3 cycles mid-T2 -> outputs frozen, and completion slips by exactly 3 cycles.
